// File: rtl/eth_tx_pkt_arbiter.sv
// eth_tx_pkt_arbiter
//   Packet-atomic round-robin arbiter. Several AXI-Stream requesters (for example
//   NIC Ethernet TX and RDMA TX) share the single engine-to-MAC TX stream. A grant
//   is held for a whole packet (until tlast). An idle cycle separates packets.
//   Software can pause a requester through src_enable, which is only looked at
//   while no packet is in flight.
//
// Optional feature macro: ETH_TX_ARB_STAT_EN
//   defined   : per-source forwarded-packet counters on src_pkt_cnt
//   undefined : src_pkt_cnt is tied to 0 (the port is still present)
//
// Ports
//   sysclk        in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   src_enable    in   [SRC_NUM]             per-source arbitration enable
//   s_axis_data   in   [SRC_NUM*DATA_WIDTH]  source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_keep   in   [SRC_NUM*KEEP_WIDTH]  same packing as data
//   s_axis_valid  in   [SRC_NUM]
//   s_axis_last   in   [SRC_NUM]
//   s_axis_ready  out  [SRC_NUM]
//   m_axis_data   out  [DATA_WIDTH]          merged stream toward the MAC bridge
//   m_axis_keep   out  [KEEP_WIDTH]
//   m_axis_valid  out
//   m_axis_last   out
//   m_axis_ready  in
//   grant_idx     out  [IDX_W]               current or most recent granted source
//   busy          out                        high while a packet is in flight
//   src_pkt_cnt   out  [SRC_NUM*32]          per-source packet counters
module eth_tx_pkt_arbiter #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int SRC_NUM    = 2,
  parameter int IDX_W      = $clog2(SRC_NUM)
) (
  input  logic                           sysclk,
  input  logic                           rst_n,
  input  logic [SRC_NUM-1:0]             src_enable,
  input  logic [SRC_NUM*DATA_WIDTH-1:0]  s_axis_data,
  input  logic [SRC_NUM*KEEP_WIDTH-1:0]  s_axis_keep,
  input  logic [SRC_NUM-1:0]             s_axis_valid,
  input  logic [SRC_NUM-1:0]             s_axis_last,
  output logic [SRC_NUM-1:0]             s_axis_ready,
  output logic [DATA_WIDTH-1:0]          m_axis_data,
  output logic [KEEP_WIDTH-1:0]          m_axis_keep,
  output logic                           m_axis_valid,
  output logic                           m_axis_last,
  input  logic                           m_axis_ready,
  output logic [IDX_W-1:0]               grant_idx,
  output logic                           busy,
  output logic [SRC_NUM*32-1:0]          src_pkt_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]            state;
  logic [IDX_W-1:0]      rr_ptr;
  logic [SRC_NUM-1:0]    req;
  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic [IDX_W-1:0]      cand;
  logic                  last_fire;

  logic [DATA_WIDTH-1:0] src_data [SRC_NUM];
  logic [KEEP_WIDTH-1:0] src_keep [SRC_NUM];

  genvar gi;
  generate
    for (gi = 0; gi < SRC_NUM; gi++) begin : g_unpack
      assign src_data[gi] = s_axis_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign src_keep[gi] = s_axis_keep[gi*KEEP_WIDTH +: KEEP_WIDTH];
      // Only the granted source sees the downstream ready, and only while busy.
      assign s_axis_ready[gi] = (state == ST_BUSY) && m_axis_ready &&
                                (grant_idx == IDX_W'(gi));
    end
  endgenerate

  assign busy = (state == ST_BUSY);
  assign req  = s_axis_valid & src_enable;

  // Round-robin pick: first requester after rr_ptr, wrapping modulo SRC_NUM.
  // Works for non-power-of-two SRC_NUM because the wrap is explicit.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= SRC_NUM; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % SRC_NUM);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Output mux: payload is forced to zero whenever the merged stream is not valid,
  // so a stalled source never leaks stale data downstream.
  assign m_axis_valid = busy && s_axis_valid[grant_idx];
  assign m_axis_data  = m_axis_valid ? src_data[grant_idx] : '0;
  assign m_axis_keep  = m_axis_valid ? src_keep[grant_idx] : '0;
  assign m_axis_last  = m_axis_valid && s_axis_last[grant_idx];

  assign last_fire = m_axis_valid && m_axis_ready && m_axis_last;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= IDX_W'(SRC_NUM - 1);
      grant_idx <= '0;
    end else if (state == ST_IDLE) begin
      if (pick_found) begin
        grant_idx <= pick_idx;
        state     <= ST_BUSY;
      end
    end else begin
      // The grant is released only at tlast; enable changes are ignored mid-packet.
      if (last_fire) begin
        rr_ptr <= grant_idx;
        state  <= ST_IDLE;
      end
    end
  end

`ifdef ETH_TX_ARB_STAT_EN
  generate
    for (gi = 0; gi < SRC_NUM; gi++) begin : g_cnt
      logic [31:0] pkt_cnt;
      always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
          pkt_cnt <= '0;
        end else if (last_fire && (grant_idx == IDX_W'(gi))) begin
          pkt_cnt <= pkt_cnt + 32'd1;  // wraps naturally at 2^32
        end
      end
      assign src_pkt_cnt[gi*32 +: 32] = pkt_cnt;
    end
  endgenerate
`else
  assign src_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_eth_tx_pkt_arbiter.sv
// Testbench for eth_tx_pkt_arbiter: randomized per-source packet drivers push
// expected beats into per-source queues; a negedge monitor tracks the arbitration
// rules at packet level and pops/compares every handshaken output beat.
module tb_eth_tx_pkt_arbiter;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int NS = 3;
  localparam int IW = $clog2(NS);

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic              sysclk = 1'b0;
  logic              rst_n  = 1'b0;
  logic [NS-1:0]     src_enable = '1;
  logic [NS*DW-1:0]  s_axis_data;
  logic [NS*KW-1:0]  s_axis_keep;
  logic [NS-1:0]     s_axis_valid;
  logic [NS-1:0]     s_axis_last;
  logic [NS-1:0]     s_axis_ready;
  logic [DW-1:0]     m_axis_data;
  logic [KW-1:0]     m_axis_keep;
  logic              m_axis_valid;
  logic              m_axis_last;
  logic              m_axis_ready = 1'b1;
  logic [IW-1:0]     grant_idx;
  logic              busy;
  logic [NS*32-1:0]  src_pkt_cnt;

  logic [DW-1:0]     src_data  [NS];
  logic [KW-1:0]     src_keep  [NS];
  logic              src_valid [NS];
  logic              src_last  [NS];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int bp_mode  = 0;   // 0: ready high, 1: toggle, 2: random
  int hs_cnt   = 0;
  int prev_hs  = -1;
  bit chk_gap  = 1'b0;

  beat_t       exp_q [NS][$];
  int          gseq [$];
  bit          m_busy  = 1'b0;
  int          m_rr    = NS - 1;
  int          m_grant = 0;
  int unsigned m_cnt [NS];
  int          pkt_beats = 0;

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_pack
      assign s_axis_data[gi*DW +: DW] = src_data[gi];
      assign s_axis_keep[gi*KW +: KW] = src_keep[gi];
      assign s_axis_valid[gi]         = src_valid[gi];
      assign s_axis_last[gi]          = src_last[gi];
    end
  endgenerate

  eth_tx_pkt_arbiter #(
    .DATA_WIDTH(DW),
    .SRC_NUM   (NS)
  ) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .src_enable  (src_enable),
    .s_axis_data (s_axis_data),
    .s_axis_keep (s_axis_keep),
    .s_axis_valid(s_axis_valid),
    .s_axis_last (s_axis_last),
    .s_axis_ready(s_axis_ready),
    .m_axis_data (m_axis_data),
    .m_axis_keep (m_axis_keep),
    .m_axis_valid(m_axis_valid),
    .m_axis_last (m_axis_last),
    .m_axis_ready(m_axis_ready),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .src_pkt_cnt (src_pkt_cnt)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  always @(posedge sysclk) begin
    #1;
    case (bp_mode)
      1:       m_axis_ready = ~m_axis_ready;
      2:       m_axis_ready = ($urandom_range(99) >= 40);
      default: m_axis_ready = 1'b1;
    endcase
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor and reference model: runs away from the active edge.
  always @(negedge sysclk) begin
    logic [127:0] ec;
    logic [NS-1:0] req;
    beat_t bt;
    int g;
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant_idx, 0);
      chk("rst_ready", s_axis_ready, 0);
      chk("rst_mout", {m_axis_valid, m_axis_last, m_axis_keep, m_axis_data}, 0);
      chk("rst_cnt", src_pkt_cnt, 0);
      m_busy = 1'b0; m_rr = NS - 1; m_grant = 0; pkt_beats = 0;
      for (int s = 0; s < NS; s++) begin
        m_cnt[s] = 0;
        exp_q[s].delete();
      end
    end else begin
      ec = '0;
`ifdef ETH_TX_ARB_STAT_EN
      for (int s = 0; s < NS; s++) ec[s*32 +: 32] = m_cnt[s];
`endif
      chk("pkt_cnt", src_pkt_cnt, ec);
      if (!m_busy) begin
        chk("idle_busy", busy, 0);
        chk("idle_grant", grant_idx, m_grant);
        chk("idle_ready", s_axis_ready, 0);
        chk("idle_mout", {m_axis_valid, m_axis_last, m_axis_keep, m_axis_data}, 0);
        for (int s = 0; s < NS; s++) req[s] = src_valid[s] & src_enable[s];
        for (int k = 1; k <= NS; k++) begin
          if (!m_busy && req[(m_rr + k) % NS]) begin
            m_busy  = 1'b1;
            m_grant = (m_rr + k) % NS;
          end
        end
      end else begin
        g = m_grant;
        chk("busy", busy, 1);
        chk("grant", grant_idx, g);
        chk("m_valid", m_axis_valid, src_valid[g]);
        chk("s_ready", s_axis_ready, m_axis_ready ? (128'd1 << g) : 128'd0);
        if (!m_axis_valid) begin
          chk("stall_zero", {m_axis_last, m_axis_keep, m_axis_data}, 0);
        end else if (m_axis_ready) begin
          hs_cnt++;
          if (chk_gap && prev_hs >= 0) chk("pkt_spacing", cyc - prev_hs, 2);
          prev_hs = cyc;
          if (exp_q[g].size() == 0) begin
            chk("beat_expected", 0, 1);
          end else begin
            bt = exp_q[g].pop_front();
            chk("beat", {m_axis_data, m_axis_keep, m_axis_last}, bt);
            pkt_beats++;
            if (bt.l) begin
              $display("pkt src=%0d beats=%0d t=%0t", g, pkt_beats, $time);
              pkt_beats = 0;
              m_busy = 1'b0;
              m_rr   = g;
              m_cnt[g]++;
              gseq.push_back(g);
            end
          end
        end
      end
    end
  end

  task automatic send_pkts(input int s, input int npkt, input int minlen,
                           input int maxlen, input int gap_pct);
    for (int p = 0; p < npkt; p++) begin
      beat_t pkt[$];
      int len;
      len = $urandom_range(maxlen, minlen);
      for (int b = 0; b < len; b++) begin
        beat_t bt;
        bt.d = $urandom;
        bt.k = KW'($urandom);
        bt.l = (b == len - 1);
        pkt.push_back(bt);
        exp_q[s].push_back(bt);
      end
      for (int b = 0; b < len; b++) begin
        int n;
        bit hs;
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
          src_valid[s] = 1'b0;
          @(posedge sysclk); #1;
        end
        src_valid[s] = 1'b1;
        src_data[s]  = pkt[b].d;
        src_keep[s]  = pkt[b].k;
        src_last[s]  = pkt[b].l;
        n = 0;
        hs = 1'b0;
        while (!hs) begin
          @(negedge sysclk);
          hs = s_axis_ready[s];
          @(posedge sysclk); #1;
          n++;
          if (!hs && n > 3000) begin
            chk("handshake_timeout", s, 128'hFF);
            src_valid[s] = 1'b0;
            return;
          end
        end
      end
    end
    src_valid[s] = 1'b0;
    src_last[s]  = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge sysclk);
    #1;
    for (int s = 0; s < NS; s++) chk("queue_drained", exp_q[s].size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every source valid.
    for (int s = 0; s < NS; s++) begin
      src_valid[s] = 1'b1;
      src_data[s]  = $urandom;
      src_keep[s]  = '1;
      src_last[s]  = 1'b1;
    end
    repeat (4) @(posedge sysclk);
    #1;
    for (int s = 0; s < NS; s++) begin
      src_valid[s] = 1'b0;
      src_last[s]  = 1'b0;
    end
    @(posedge sysclk); #1;
    rst_n = 1'b1;

    // Strict rotation with all sources continuously valid.
    gseq.delete();
    fork
      send_pkts(0, 2, 3, 3, 0);
      send_pkts(1, 2, 3, 3, 0);
      send_pkts(2, 2, 3, 3, 0);
    join
    drain();
    chk("rot_len", gseq.size(), 6);
    for (int i = 0; i < gseq.size(); i++) chk("rot_order", gseq[i], i % NS);

    // Enable mask: src0 masked until mid-packet of src1.
    src_enable = 3'b010;
    gseq.delete();
    fork
      send_pkts(0, 1, 2, 2, 0);
      send_pkts(1, 2, 4, 4, 0);
      begin
        int n;
        n = 0;
        while (!(busy && grant_idx == 1) && n < 200) begin
          @(negedge sysclk);
          n++;
        end
        chk("grant1_seen", n < 200, 1);
        @(posedge sysclk); #1;
        src_enable = 3'b011;
      end
    join
    drain();
    chk("en_len", gseq.size(), 3);
    if (gseq.size() == 3) begin
      chk("en_order0", gseq[0], 1);
      chk("en_order1", gseq[1], 0);
      chk("en_order2", gseq[2], 1);
    end
    src_enable = 3'b111;

    // Toggling backpressure on a 4-beat packet.
    bp_mode = 1;
    hs_cnt = 0;
    send_pkts(0, 1, 4, 4, 0);
    drain();
    chk("bp_beats", hs_cnt, 4);
    bp_mode = 0;

    // Single-beat packets from src0 only: one packet per two cycles.
    chk_gap = 1'b1;
    prev_hs = -1;
    hs_cnt = 0;
    send_pkts(0, 8, 1, 1, 0);
    drain();
    chk_gap = 1'b0;
    chk("single_beats", hs_cnt, 8);

    // Random traffic, random backpressure, random valid gaps.
    bp_mode = 2;
    fork
      send_pkts(0, 6, 1, 6, 30);
      send_pkts(1, 6, 1, 6, 30);
      send_pkts(2, 6, 1, 6, 30);
    join
    drain();
    bp_mode = 0;

    // Reset in the middle of a 5-beat packet after two beats.
    begin
      beat_t pkt[$];
      int b, n;
      bit hs;
      for (int i = 0; i < 5; i++) begin
        beat_t bt;
        bt.d = $urandom; bt.k = KW'($urandom); bt.l = (i == 4);
        pkt.push_back(bt);
        exp_q[0].push_back(bt);
      end
      b = 0; n = 0;
      src_valid[0] = 1'b1;
      src_data[0] = pkt[0].d; src_keep[0] = pkt[0].k; src_last[0] = pkt[0].l;
      while (b < 2 && n < 100) begin
        @(negedge sysclk);
        hs = s_axis_ready[0];
        @(posedge sysclk); #1;
        n++;
        if (hs) begin
          b++;
          src_data[0] = pkt[b].d; src_keep[0] = pkt[b].k; src_last[0] = pkt[b].l;
        end
      end
      chk("two_beats_before_reset", b, 2);
      rst_n = 1'b0;
      src_valid[0] = 1'b0;
      src_last[0] = 1'b0;
      #1;
      chk("async_rst_busy", busy, 0);
      chk("async_rst_valid", m_axis_valid, 0);
      repeat (2) @(posedge sysclk);
      #1;
      rst_n = 1'b1;
      gseq.delete();
      send_pkts(0, 2, 5, 5, 0);
      drain();
      chk("post_rst_pkts", gseq.size(), 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
